// File: rtl/top_level_fpga.sv
// Eight-digit multiplexed seven-segment driver showing a free-running 32-bit counter in hex.
// Two independent prescalers: one advances the value, the other steps the scanned digit.
module top_level_fpga #(
    parameter int TICK_DIV    = 5000000,
    parameter int REFRESH_DIV = 5000
) (
    input  logic       Clk,
    input  logic       Reset,
    output logic [6:0] out7,
    output logic [7:0] en_out
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [RW-1:0] REF_LAST  = RW'(REFRESH_DIV - 1);

    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic [RW-1:0] ref_cnt_q, ref_cnt_d;
    logic [31:0]   val_q, val_d;
    logic [2:0]    idx_q, idx_d;
    logic [3:0]    nibble;

    always_comb begin
        tick_cnt_d = tick_cnt_q + 1'b1;
        val_d      = val_q;
        ref_cnt_d  = ref_cnt_q + 1'b1;
        idx_d      = idx_q;
        if (tick_cnt_q == TICK_LAST) begin
            tick_cnt_d = '0;
            val_d      = val_q + 32'd1;
        end
        // idx is 3 bits, so 7 + 1 wraps to digit 0 without extra logic.
        if (ref_cnt_q == REF_LAST) begin
            ref_cnt_d = '0;
            idx_d     = idx_q + 3'd1;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            tick_cnt_q <= '0;
            ref_cnt_q  <= '0;
            val_q      <= '0;
            idx_q      <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            ref_cnt_q  <= ref_cnt_d;
            val_q      <= val_d;
            idx_q      <= idx_d;
        end
    end

    // Outputs decode registered state only, so the anode and segment drives stay aligned.
    always_comb begin
        nibble = val_q[{idx_q, 2'b00} +: 4];
        en_out = ~(8'b0000_0001 << idx_q);
    end

    always_comb begin
        out7 = 7'h7F;
        case (nibble)
            4'h0: out7 = 7'h40;
            4'h1: out7 = 7'h79;
            4'h2: out7 = 7'h24;
            4'h3: out7 = 7'h30;
            4'h4: out7 = 7'h19;
            4'h5: out7 = 7'h12;
            4'h6: out7 = 7'h02;
            4'h7: out7 = 7'h78;
            4'h8: out7 = 7'h00;
            4'h9: out7 = 7'h10;
            4'hA: out7 = 7'h08;
            4'hB: out7 = 7'h03;
            4'hC: out7 = 7'h46;
            4'hD: out7 = 7'h21;
            4'hE: out7 = 7'h06;
            4'hF: out7 = 7'h0E;
            default: out7 = 7'h7F;
        endcase
    end

endmodule

// File: tb/tb_top_level_fpga.sv
// Directed bench: five instances with different prescaler settings share one clock and reset.
module tb_top_level_fpga;

    logic Clk;
    logic Reset;

    logic [6:0] scan_out7, cnt_out7, sweep_out7, wrap_out7, mid_out7;
    logic [7:0] scan_en, cnt_en, sweep_en, wrap_en, mid_en;

    int errors;
    int checks;

    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    logic [7:0] scan_exp [9] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F, 8'hFE};

    top_level_fpga #(.TICK_DIV(1000), .REFRESH_DIV(2)) u_scan (
        .Clk(Clk), .Reset(Reset), .out7(scan_out7), .en_out(scan_en));
    top_level_fpga #(.TICK_DIV(4), .REFRESH_DIV(1000)) u_cnt (
        .Clk(Clk), .Reset(Reset), .out7(cnt_out7), .en_out(cnt_en));
    top_level_fpga #(.TICK_DIV(1), .REFRESH_DIV(100)) u_sweep (
        .Clk(Clk), .Reset(Reset), .out7(sweep_out7), .en_out(sweep_en));
    top_level_fpga #(.TICK_DIV(1), .REFRESH_DIV(1)) u_wrap (
        .Clk(Clk), .Reset(Reset), .out7(wrap_out7), .en_out(wrap_en));
    top_level_fpga #(.TICK_DIV(1), .REFRESH_DIV(50)) u_mid (
        .Clk(Clk), .Reset(Reset), .out7(mid_out7), .en_out(mid_en));

    // clock/reset: 200 ns period
    initial Clk = 1'b0;
    always #100 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic check_all_reset_state(input string tag);
        check({tag, "_scan_en"}, 32'(scan_en), 32'hFE);
        check({tag, "_scan_seg"}, 32'(scan_out7), 32'h40);
        check({tag, "_cnt_en"}, 32'(cnt_en), 32'hFE);
        check({tag, "_cnt_seg"}, 32'(cnt_out7), 32'h40);
        check({tag, "_sweep_seg"}, 32'(sweep_out7), 32'h40);
        check({tag, "_wrap_en"}, 32'(wrap_en), 32'hFE);
        check({tag, "_mid_en"}, 32'(mid_en), 32'hFE);
        check({tag, "_mid_seg"}, 32'(mid_out7), 32'h40);
    endtask

    // advance one rising edge, then sample on the following falling edge
    task automatic step();
        @(posedge Clk);
        @(negedge Clk);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        Reset  = 1'b1;
        #50;
        check_all_reset_state("in_reset");
        #10 Reset = 1'b0;
        #1;
        check_all_reset_state("after_release");

        for (int e = 1; e <= 291; e++) begin
            step();
            if (e <= 17) begin
                check("scan_en", 32'(scan_en), 32'(scan_exp[e/2]));
                check("scan_seg", 32'(scan_out7), 32'h40);
            end
            if (e == 3) check("cnt_before_tick", 32'(cnt_out7), 32'h40);
            if (e == 4) check("cnt_first_tick", 32'(cnt_out7), 32'h79);
            if (e == 40) check("cnt_val_a", 32'(cnt_out7), 32'h08);
            if (e <= 15) check("sweep_seg", 32'(sweep_out7), 32'(seg_tab[e]));
            if (e == 16) begin
                check("sweep_val16_seg", 32'(sweep_out7), 32'h40);
                check("sweep_digit1_nibble", 32'(u_sweep.val_q[7:4]), 32'h1);
            end
            if (e == 7) begin
                check("wrap_pre_en", 32'(wrap_en), 32'h7F);
                check("wrap_pre_seg", 32'(wrap_out7), 32'h40);
                force u_wrap.val_q = 32'hFFFFFFFF;
                #1;
                check("wrap_digit7_f", 32'(wrap_out7), 32'h0E);
                release u_wrap.val_q;
            end
            if (e == 8) check("wrap_val_zero", u_wrap.val_q, 32'h0);
            if (e >= 8 && e <= 15) begin
                check("wrap_post_en", 32'(wrap_en), 32'(scan_exp[e-8]));
                check("wrap_post_seg", 32'(wrap_out7), 32'h40);
            end
            if (e == 291) begin
                check("mid_val", u_mid.val_q, 32'h123);
                check("mid_en_idx5", 32'(mid_en), 32'hDF);
                check("mid_seg", 32'(mid_out7), 32'h40);
                check("sweep_idx2_seg", 32'(sweep_out7), 32'h79);
            end
        end

        // mid-run reset pulse, wholly between clock edges
        #10 Reset = 1'b1;
        #10;
        check_all_reset_state("mid_reset");
        check("mid_reset_val", u_mid.val_q, 32'h0);
        #20 Reset = 1'b0;

        for (int f = 1; f <= 50; f++) begin
            step();
            if (f == 1) begin
                check("resume_mid_val", u_mid.val_q, 32'h1);
                check("resume_mid_seg", 32'(mid_out7), 32'h79);
                check("resume_mid_en", 32'(mid_en), 32'hFE);
            end
            if (f == 3) check("resume_cnt_hold", 32'(cnt_out7), 32'h40);
            if (f == 4) check("resume_cnt_tick", 32'(cnt_out7), 32'h79);
            if (f == 50) begin
                check("resume_mid_idx1", 32'(mid_en), 32'hFD);
                check("resume_mid_digit1", 32'(mid_out7), 32'h30);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
